sw_mem_cfg_regs: RTL and testbench

Switch-side consumer of the memory-configuration bus (mem_en/mem_wr/mem_addr/mem_data) driven by the testbench memory driver. It holds the per-output-port destination addresses used by the packet router, tracks configuration completeness and duplicates with a small FSM, and answers one-cycle address lookups from the router's input parser. Writes are blocked while the router reports packets in flight.

---
 rtl/sw_cfg_pkg.sv | 13 +
 rtl/sw_cfg_lookup.sv | 36 +++
 rtl/sw_mem_cfg_regs.sv | 89 ++++++++
 tb/tb_sw_mem_cfg_regs.sv | 134 +++++++++++++
 4 files changed

// File: rtl/sw_cfg_pkg.sv
// sw_cfg_pkg: shared types and default sizes for the switch memory-configuration registers.
package sw_cfg_pkg;
  localparam int NUM_PORTS_D = 4;
  localparam int ADDR_W_D = 2;
  localparam int DATA_W_D = 8;
  typedef enum logic [1:0] {
    UNCFG   = 2'd0,
    PARTIAL = 2'd1,
    READY   = 2'd2,
    DUP_ERR = 2'd3
  } cfg_state_e;
  typedef logic [NUM_PORTS_D*DATA_W_D-1:0] port_addr_t;
endpackage

// File: rtl/sw_cfg_lookup.sv
// sw_cfg_lookup: one-cycle destination lookup, lowest written matching entry wins.
module sw_cfg_lookup #(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          lookup_valid,
  input  logic [DATA_W-1:0]             lookup_da,
  input  logic [NUM_PORTS*DATA_W-1:0]   entries,
  input  logic [NUM_PORTS-1:0]          mask,
  output logic                          lookup_done,
  output logic                          lookup_hit,
  output logic [NUM_PORTS-1:0]          lookup_port
);
  logic [NUM_PORTS-1:0] match;
  logic [NUM_PORTS-1:0] first;
  always_comb begin
    match = '0;
    for (int i = 0; i < NUM_PORTS; i++)
      match[i] = mask[i] && (entries[i*DATA_W +: DATA_W] == lookup_da);
  end
  // isolate the lowest set bit so the result stays one-hot
  assign first = match & (~match + NUM_PORTS'(1));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lookup_done <= 1'b0;
      lookup_hit  <= 1'b0;
      lookup_port <= '0;
    end else begin
      lookup_done <= lookup_valid;
      lookup_hit  <= lookup_valid && |match;
      lookup_port <= lookup_valid ? first : '0;
    end
  end
endmodule

// File: rtl/sw_mem_cfg_regs.sv
// sw_mem_cfg_regs: per-port destination address registers with completeness/duplicate FSM and lookup.
// Build option CFG_READBACK_EN adds the config-bus read path; otherwise reads are ignored.
module sw_mem_cfg_regs
  import sw_cfg_pkg::*;
#(
  parameter int NUM_PORTS = NUM_PORTS_D,
  parameter int ADDR_W = ADDR_W_D,
  parameter int DATA_W = DATA_W_D
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        mem_en,
  input  logic                        mem_wr,
  input  logic [ADDR_W-1:0]           mem_addr,
  input  logic [DATA_W-1:0]           mem_data,
  output logic [DATA_W-1:0]           mem_rdata,
  output logic                        mem_rvalid,
  output logic                        wr_err,
  input  logic                        cfg_lock,
  input  logic                        lookup_valid,
  input  logic [DATA_W-1:0]           lookup_da,
  output logic                        lookup_done,
  output logic                        lookup_hit,
  output logic [NUM_PORTS-1:0]        lookup_port,
  output logic [1:0]                  cfg_state,
  output logic [NUM_PORTS*DATA_W-1:0] port_addr
);
  logic [DATA_W-1:0]    ent [NUM_PORTS];
  logic [NUM_PORTS-1:0] mask;
  logic                 dup;
  cfg_state_e           state, nxt;
  wire wr_req = mem_en && mem_wr;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_PORTS; i++) ent[i] <= '0;
      mask   <= '0;
      wr_err <= 1'b0;
    end else begin
      wr_err <= wr_req && cfg_lock;
      if (wr_req && !cfg_lock) begin
        ent[mem_addr]  <= mem_data;
        mask[mem_addr] <= 1'b1;
      end
    end
  end
  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_flat
    assign port_addr[g*DATA_W +: DATA_W] = ent[g];
  end
`ifdef CFG_READBACK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_rvalid <= 1'b0;
      mem_rdata  <= '0;
    end else begin
      mem_rvalid <= mem_en && !mem_wr;
      mem_rdata  <= (mem_en && !mem_wr) ? ent[mem_addr] : '0;
    end
  end
`else
  assign mem_rvalid = 1'b0;
  assign mem_rdata  = '0;
`endif
  always_comb begin
    dup = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++)
      for (int j = i + 1; j < NUM_PORTS; j++)
        if (ent[i] == ent[j]) dup = 1'b1;
  end
  // driven from registered mask/entries, so the state trails the write by one cycle
  assign nxt = (state == UNCFG)   ? (|mask ? PARTIAL : UNCFG) :
               (state == PARTIAL) ? (&mask ? (dup ? DUP_ERR : READY) : PARTIAL) :
               dup ? DUP_ERR : READY;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= UNCFG;
    else     state <= nxt;
  end
  assign cfg_state = state;
  sw_cfg_lookup #(.NUM_PORTS(NUM_PORTS), .DATA_W(DATA_W)) u_lookup (
    .clk          (clk),
    .rst          (rst),
    .lookup_valid (lookup_valid),
    .lookup_da    (lookup_da),
    .entries      (port_addr),
    .mask         (mask),
    .lookup_done  (lookup_done),
    .lookup_hit   (lookup_hit),
    .lookup_port  (lookup_port)
  );
endmodule

// File: tb/tb_sw_mem_cfg_regs.sv
// tb_sw_mem_cfg_regs: directed self-checking bench for sw_mem_cfg_regs.
module tb_sw_mem_cfg_regs;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_en = 1'b0, mem_wr = 1'b0;
  logic [1:0]  mem_addr = '0;
  logic [7:0]  mem_data = '0;
  logic [7:0]  mem_rdata;
  logic        mem_rvalid, wr_err;
  logic        cfg_lock = 1'b0;
  logic        lookup_valid = 1'b0;
  logic [7:0]  lookup_da = '0;
  logic        lookup_done, lookup_hit;
  logic [3:0]  lookup_port;
  logic [1:0]  cfg_state;
  logic [31:0] port_addr;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  sw_mem_cfg_regs dut (
    .clk(clk), .rst(rst), .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .wr_err(wr_err),
    .cfg_lock(cfg_lock), .lookup_valid(lookup_valid), .lookup_da(lookup_da),
    .lookup_done(lookup_done), .lookup_hit(lookup_hit), .lookup_port(lookup_port),
    .cfg_state(cfg_state), .port_addr(port_addr)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    mem_en = 1'b1; mem_wr = 1'b1; mem_addr = a; mem_data = d;
    tick();
    mem_en = 1'b0; mem_wr = 1'b0;
  endtask

  task automatic lk(input logic [7:0] da);
    lookup_valid = 1'b1; lookup_da = da;
    tick();
    lookup_valid = 1'b0;
  endtask

  initial begin
    tick(); tick();
    chk("rst_state", cfg_state, 0);
    chk("rst_port_addr", port_addr, 0);
    chk("rst_outs", {lookup_done, lookup_hit, lookup_port, wr_err, mem_rvalid, mem_rdata}, 0);
    rst = 1'b0;
    wr(0, 8'h10);
    chk("state_lag", cfg_state, 0);
    wr(1, 8'h20);
    chk("state_partial", cfg_state, 1);
    wr(2, 8'h30);
    wr(3, 8'h40);
    chk("full_port_addr", port_addr, 32'h40302010);
    chk("state_pre_ready", cfg_state, 1);
    tick();
    chk("state_ready", cfg_state, 2);
    wr(2, 8'h10);
    tick();
    chk("state_dup", cfg_state, 3);
    lk(8'h10);
    chk("dup_lookup", {lookup_done, lookup_hit, lookup_port}, {1'b1, 1'b1, 4'b0001});
    wr(2, 8'h33);
    tick();
    chk("state_unique", cfg_state, 2);
    cfg_lock = 1'b1;
    wr(1, 8'hFF);
    chk("wr_err_pulse", wr_err, 1);
    chk("locked_entry", port_addr[15:8], 8'h20);
    tick();
    chk("wr_err_clear", wr_err, 0);
    chk("locked_state", cfg_state, 2);
    cfg_lock = 1'b0;
    wr(2, 8'h30);
    tick();
    chk("restore_addr", port_addr, 32'h40302010);
    lookup_valid = 1'b1; lookup_da = 8'h30;
    tick();
    chk("b2b_0", {lookup_done, lookup_hit, lookup_port}, {1'b1, 1'b1, 4'b0100});
    lookup_da = 8'h55;
    tick();
    chk("b2b_1", {lookup_done, lookup_hit, lookup_port}, {1'b1, 1'b0, 4'b0000});
    lookup_da = 8'h40;
    tick();
    chk("b2b_2", {lookup_done, lookup_hit, lookup_port}, {1'b1, 1'b1, 4'b1000});
    lookup_valid = 1'b0;
    tick();
    chk("b2b_idle", lookup_done, 0);
    mem_en = 1'b1; mem_wr = 1'b0; mem_addr = 2'd3;
    lookup_valid = 1'b1; lookup_da = 8'h20;
    tick();
    mem_en = 1'b0; lookup_valid = 1'b0;
`ifdef CFG_READBACK_EN
    chk("read_data", {mem_rvalid, mem_rdata}, {1'b1, 8'h40});
`else
    chk("read_data", {mem_rvalid, mem_rdata}, 0);
`endif
    chk("read_lookup", {lookup_done, lookup_hit, lookup_port}, {1'b1, 1'b1, 4'b0010});
    tick();
    chk("read_idle", {mem_rvalid, mem_rdata, lookup_done}, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wr(0, 8'h10);
    wr(1, 8'h20);
    lk(8'h10);
    chk("pre_rst_lookup", {lookup_done, lookup_hit, lookup_port}, {1'b1, 1'b1, 4'b0001});
    chk("pre_rst_state", cfg_state, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_outs", {lookup_done, lookup_hit, lookup_port}, 0);
    chk("async_rst_state", cfg_state, 0);
    chk("async_rst_addr", port_addr, 0);
    tick();
    rst = 1'b0;
    lk(8'h10);
    chk("post_rst_miss", {lookup_done, lookup_hit, lookup_port}, {1'b1, 1'b0, 4'b0000});
    chk("post_rst_state", cfg_state, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
